// File: rtl/mem_arb_pkg.sv
// Shared types and default build constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_AW        = 8;
    localparam int unsigned DEF_DW        = 16;
    localparam int unsigned DEF_LAT       = 2;
    localparam int unsigned DEF_MAX_DEFER = 2;

    // Counter widths sized for the legal parameter ranges (LAT 1..7, MAX_DEFER 1..3).
    localparam int unsigned WAIT_CW  = 3;
    localparam int unsigned DEFER_CW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between fetch and data ports, with the fetch-deferral counter
// that forces a fetch grant after MAX_DEFER consecutive losses.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DEFER = DEF_MAX_DEFER
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   sample,
    input  logic   if_req_c,
    input  logic   dm_req,
    output logic   any_req_c,
    output owner_t grant_c
);

    logic [DEFER_CW-1:0] defer_cnt;
    logic                both_c;
    logic                defer_full_c;

    assign both_c       = if_req_c & dm_req;
    assign any_req_c    = if_req_c | dm_req;
    assign defer_full_c = (defer_cnt == DEFER_CW'(MAX_DEFER));

    // Data wins unless it is absent or fetch has already lost MAX_DEFER times in a row.
    always_comb begin
        grant_c = DATA;
        if (!dm_req || (both_c && defer_full_c)) begin
            grant_c = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            defer_cnt <= '0;
        end else if (sample && any_req_c) begin
            if (grant_c == FETCH) begin
                defer_cnt <= '0;
            end else if (both_c && !defer_full_c) begin
                defer_cnt <= defer_cnt + DEFER_CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports: issue,
// fixed-latency wait, one-cycle response, with per-port stall outputs.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned LAT       = DEF_LAT,
    parameter int unsigned MAX_DEFER = DEF_MAX_DEFER
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_kill,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t               state_q, state_d;
    owner_t               owner_q, owner_d;
    logic                 kill_q, kill_d;
    logic [WAIT_CW-1:0]   wait_q, wait_d;
    logic                 we_q;
    logic                 load_c;
    logic                 capture_c;
    logic                 sel_if_req_c;
    logic                 any_req_c;
    owner_t               grant_c;

    assign sel_if_req_c = if_req & ~if_kill;

    mem_arb_select #(
        .MAX_DEFER (MAX_DEFER)
    ) u_select (
        .clk       (clk),
        .rst       (rst),
        .sample    (state_q == IDLE),
        .if_req_c  (sel_if_req_c),
        .dm_req    (dm_req),
        .any_req_c (any_req_c),
        .grant_c   (grant_c)
    );

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

    // Next-state logic; a killed fetch still runs to completion since the memory cannot abort.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        kill_d    = kill_q;
        wait_d    = wait_q;
        load_c    = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (any_req_c) begin
                    load_c  = 1'b1;
                    owner_d = grant_c;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                kill_d = kill_q || (if_kill && (owner_q == FETCH));
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    wait_d  = WAIT_CW'(LAT);
                end
            end
            WAIT: begin
                kill_d = kill_q || (if_kill && (owner_q == FETCH));
                wait_d = wait_q - WAIT_CW'(1);
                if (wait_q == WAIT_CW'(1)) begin
                    capture_c = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= FETCH;
            kill_q  <= 1'b0;
            wait_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            kill_q  <= kill_d;
            wait_q  <= wait_d;
            if (load_c) begin
                we_q <= (grant_c == DATA) && dm_we;
            end
        end
    end

    // Registered memory command and response outputs, all driven from next-cycle values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            mem_en   <= load_c;
            mem_we   <= load_c && (grant_c == DATA) && dm_we;
            if (load_c) begin
                mem_addr  <= (grant_c == DATA) ? dm_addr : if_addr;
                mem_wdata <= (grant_c == DATA) ? dm_wdata : '0;
            end
            if_valid <= (state_d == RESP) && (owner_q == FETCH) && !kill_d;
            dm_valid <= (state_d == RESP) && (owner_q == DATA);
            if (capture_c && (owner_q == FETCH)) begin
                if_rdata <= mem_rdata;
            end
            if (capture_c && (owner_q == DATA)) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=2 main instance plus LAT=1 and LAT=7
// instances sharing the same stimulus, each with its own fixed-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic        if_kill = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [7:0]  dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic [15:0] rd_word = '0;

    logic [15:0] if_rdata_v  [3];
    logic        if_valid_v  [3];
    logic [15:0] dm_rdata_v  [3];
    logic        dm_valid_v  [3];
    logic        stall_if_v  [3];
    logic        stall_mem_v [3];
    logic        mem_en_v    [3];
    logic        mem_we_v    [3];
    logic [7:0]  mem_addr_v  [3];
    logic [15:0] mem_wdata_v [3];
    logic [15:0] mem_rdata_v [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
        logic [3:0] pend_cnt = '0;

        // Memory returns rd_word exactly LAT cycles after a read command, garbage otherwise.
        always @(posedge clk) begin
            if (mem_en_v[g] && !mem_we_v[g]) pend_cnt <= 4'(L);
            else if (pend_cnt != 4'd0)       pend_cnt <= pend_cnt - 4'd1;
        end
        assign mem_rdata_v[g] = (pend_cnt == 4'd1) ? rd_word : 16'hDEAD;

        mem_port_arbiter #(
            .AW(8), .DW(16), .LAT(L), .MAX_DEFER(2)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_kill   (if_kill),
            .if_rdata  (if_rdata_v[g]),
            .if_valid  (if_valid_v[g]),
            .dm_req    (dm_req),
            .dm_we     (dm_we),
            .dm_addr   (dm_addr),
            .dm_wdata  (dm_wdata),
            .dm_rdata  (dm_rdata_v[g]),
            .dm_valid  (dm_valid_v[g]),
            .stall_if  (stall_if_v[g]),
            .stall_mem (stall_mem_v[g]),
            .mem_en    (mem_en_v[g]),
            .mem_we    (mem_we_v[g]),
            .mem_addr  (mem_addr_v[g]),
            .mem_wdata (mem_wdata_v[g]),
            .mem_rdata (mem_rdata_v[g])
        );
    end

    typedef struct {
        logic        ir, ik, dr, dw;
        logic [7:0]  ia, da;
        logic [15:0] wd, rw;
        logic        en, we, iv, dv, si, sm;
        logic [7:0]  ea;
        logic [15:0] ewd, eir, edr;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    function automatic vec_t v(input logic ir, ik, dr, dw, input logic [7:0] ia, da,
                               input logic [15:0] wd, rw, input logic en, we, iv, dv, si, sm,
                               input logic [7:0] ea, input logic [15:0] ewd, eir, edr);
        vec_t r;
        r.ir = ir; r.ik = ik; r.dr = dr; r.dw = dw; r.ia = ia; r.da = da; r.wd = wd; r.rw = rw;
        r.en = en; r.we = we; r.iv = iv; r.dv = dv; r.si = si; r.sm = sm;
        r.ea = ea; r.ewd = ewd; r.eir = eir; r.edr = edr;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          en_cnt;
        int          iv_cnt;
        int          ng;
        int          lat;
        int          first [3];
        logic [7:0]  got [6];
        logic [7:0]  exp_g [6];

        // Per-cycle vectors: inputs applied this cycle, outputs expected in the same cycle.
        tbl[0]  = v(1,0,0,0,8'h10,8'h00,16'h0000,16'hA5A5, 0,0,0,0,1,0, 8'h00,16'h0000,16'h0000,16'h0000);
        tbl[1]  = v(1,0,0,0,8'h10,8'h00,16'h0000,16'hA5A5, 1,0,0,0,1,0, 8'h10,16'h0000,16'h0000,16'h0000);
        tbl[2]  = v(1,0,0,0,8'h10,8'h00,16'h0000,16'hA5A5, 0,0,0,0,1,0, 8'h00,16'h0000,16'h0000,16'h0000);
        tbl[3]  = v(1,0,0,0,8'h10,8'h00,16'h0000,16'hA5A5, 0,0,0,0,1,0, 8'h00,16'h0000,16'h0000,16'h0000);
        tbl[4]  = v(1,0,0,0,8'h10,8'h00,16'h0000,16'hA5A5, 0,0,1,0,0,0, 8'h00,16'h0000,16'hA5A5,16'h0000);
        tbl[5]  = v(0,0,0,0,8'h00,8'h00,16'h0000,16'h0000, 0,0,0,0,0,0, 8'h00,16'h0000,16'hA5A5,16'h0000);
        tbl[6]  = v(0,0,1,1,8'h00,8'h20,16'h1234,16'h0000, 0,0,0,0,0,1, 8'h00,16'h0000,16'hA5A5,16'h0000);
        tbl[7]  = v(0,0,1,1,8'h00,8'h20,16'h1234,16'h0000, 1,1,0,0,0,1, 8'h20,16'h1234,16'hA5A5,16'h0000);
        tbl[8]  = v(0,0,1,1,8'h00,8'h20,16'h1234,16'h0000, 0,0,0,1,0,0, 8'h00,16'h0000,16'hA5A5,16'h0000);
        tbl[9]  = v(0,0,0,0,8'h00,8'h00,16'h0000,16'h0000, 0,0,0,0,0,0, 8'h00,16'h0000,16'hA5A5,16'h0000);
        tbl[10] = v(0,0,1,0,8'h00,8'h30,16'h0000,16'h5A3C, 0,0,0,0,0,1, 8'h00,16'h0000,16'hA5A5,16'h0000);
        tbl[11] = v(0,0,1,0,8'h00,8'h30,16'h0000,16'h5A3C, 1,0,0,0,0,1, 8'h30,16'h0000,16'hA5A5,16'h0000);
        tbl[12] = v(0,0,1,0,8'h00,8'h30,16'h0000,16'h5A3C, 0,0,0,0,0,1, 8'h00,16'h0000,16'hA5A5,16'h0000);
        tbl[13] = v(0,0,1,0,8'h00,8'h30,16'h0000,16'h5A3C, 0,0,0,0,0,1, 8'h00,16'h0000,16'hA5A5,16'h0000);
        tbl[14] = v(0,0,1,0,8'h00,8'h30,16'h0000,16'h5A3C, 0,0,0,1,0,0, 8'h00,16'h0000,16'hA5A5,16'h5A3C);
        tbl[15] = v(0,0,0,0,8'h00,8'h00,16'h0000,16'h0000, 0,0,0,0,0,0, 8'h00,16'h0000,16'hA5A5,16'h5A3C);
        tbl[16] = v(1,1,0,0,8'h44,8'h00,16'h0000,16'h0F0F, 0,0,0,0,1,0, 8'h00,16'h0000,16'hA5A5,16'h5A3C);
        tbl[17] = v(1,0,0,0,8'h44,8'h00,16'h0000,16'h0F0F, 0,0,0,0,1,0, 8'h00,16'h0000,16'hA5A5,16'h5A3C);
        tbl[18] = v(1,0,0,0,8'h44,8'h00,16'h0000,16'h0F0F, 1,0,0,0,1,0, 8'h44,16'h0000,16'hA5A5,16'h5A3C);
        tbl[19] = v(1,0,0,0,8'h44,8'h00,16'h0000,16'h0F0F, 0,0,0,0,1,0, 8'h00,16'h0000,16'hA5A5,16'h5A3C);
        tbl[20] = v(1,0,0,0,8'h44,8'h00,16'h0000,16'h0F0F, 0,0,0,0,1,0, 8'h00,16'h0000,16'hA5A5,16'h5A3C);
        tbl[21] = v(1,0,0,0,8'h44,8'h00,16'h0000,16'h0F0F, 0,0,1,0,0,0, 8'h00,16'h0000,16'h0F0F,16'h5A3C);
        tbl[22] = v(0,0,0,0,8'h00,8'h00,16'h0000,16'h0000, 0,0,0,0,0,0, 8'h00,16'h0000,16'h0F0F,16'h5A3C);

        // Reset state
        @(negedge clk); #1;
        chk("rst mem_en",   32'(mem_en_v[0]),   32'h0);
        chk("rst mem_addr", 32'(mem_addr_v[0]), 32'h0);
        chk("rst if_valid", 32'(if_valid_v[0]), 32'h0);
        chk("rst dm_valid", 32'(dm_valid_v[0]), 32'h0);
        chk("rst if_rdata", 32'(if_rdata_v[0]), 32'h0);
        chk("rst dm_rdata", 32'(dm_rdata_v[0]), 32'h0);
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if_req = tbl[i].ir; if_kill = tbl[i].ik; if_addr = tbl[i].ia;
            dm_req = tbl[i].dr; dm_we = tbl[i].dw; dm_addr = tbl[i].da;
            dm_wdata = tbl[i].wd; rd_word = tbl[i].rw;
            #1;
            chk($sformatf("v%0d mem_en", i),    32'(mem_en_v[0]),    32'(tbl[i].en));
            chk($sformatf("v%0d mem_we", i),    32'(mem_we_v[0]),    32'(tbl[i].we));
            chk($sformatf("v%0d if_valid", i),  32'(if_valid_v[0]),  32'(tbl[i].iv));
            chk($sformatf("v%0d dm_valid", i),  32'(dm_valid_v[0]),  32'(tbl[i].dv));
            chk($sformatf("v%0d stall_if", i),  32'(stall_if_v[0]),  32'(tbl[i].si));
            chk($sformatf("v%0d stall_mem", i), 32'(stall_mem_v[0]), 32'(tbl[i].sm));
            chk($sformatf("v%0d if_rdata", i),  32'(if_rdata_v[0]),  32'(tbl[i].eir));
            chk($sformatf("v%0d dm_rdata", i),  32'(dm_rdata_v[0]),  32'(tbl[i].edr));
            if (tbl[i].en) chk($sformatf("v%0d mem_addr", i),  32'(mem_addr_v[0]),  32'(tbl[i].ea));
            if (tbl[i].we) chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata_v[0]), 32'(tbl[i].ewd));
        end

        // Fetch killed during WAIT: one memory command, no if_valid, idle again at T+5
        @(negedge clk);
        if_req = 1'b1; if_addr = 8'h50; rd_word = 16'h1111;
        en_cnt = 0; iv_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 2) begin if_kill = 1'b1; if_req = 1'b0; end
            else if_kill = 1'b0;
            if (k == 5) begin if_req = 1'b1; if_addr = 8'h54; rd_word = 16'h7777; end
            #1;
            en_cnt += int'(mem_en_v[0]);
            iv_cnt += int'(if_valid_v[0]);
        end
        chk("kill mem_en count", 32'(en_cnt), 32'd1);
        chk("kill if_valid count", 32'(iv_cnt), 32'd0);
        @(negedge clk); #1;
        chk("post-kill mem_en T+6", 32'(mem_en_v[0]), 32'h1);
        chk("post-kill mem_addr", 32'(mem_addr_v[0]), 32'h54);
        repeat (3) @(negedge clk);
        #1;
        chk("post-kill if_valid T+9", 32'(if_valid_v[0]), 32'h1);
        chk("post-kill if_rdata", 32'(if_rdata_v[0]), 32'h7777);
        @(negedge clk); if_req = 1'b0;
        repeat (12) @(negedge clk);

        // Both ports held: grant order DATA, DATA, FETCH, repeating
        exp_g = '{8'h80, 8'h80, 8'h90, 8'h80, 8'h80, 8'h90};
        @(negedge clk);
        if_req = 1'b1; if_addr = 8'h90;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h80; dm_wdata = 16'hCAFE;
        ng = 0;
        for (int k = 0; k < 80 && ng < 6; k++) begin
            @(negedge clk); #1;
            if (mem_en_v[0]) begin
                got[ng] = mem_addr_v[0];
                ng++;
            end
        end
        chk("arb grant count", 32'(ng), 32'd6);
        for (int i = 0; i < ng; i++) chk($sformatf("arb grant %0d", i), 32'(got[i]), 32'(exp_g[i]));
        @(negedge clk); if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        repeat (12) @(negedge clk);

        // Reset mid-WAIT of a data read
        @(negedge clk); dm_req = 1'b1; dm_addr = 8'h60; rd_word = 16'h2468;
        repeat (3) @(negedge clk);
        rst = 1'b0; dm_req = 1'b0;
        #1;
        chk("arst mem_en",    32'(mem_en_v[0]),    32'h0);
        chk("arst mem_we",    32'(mem_we_v[0]),    32'h0);
        chk("arst mem_addr",  32'(mem_addr_v[0]),  32'h0);
        chk("arst mem_wdata", 32'(mem_wdata_v[0]), 32'h0);
        chk("arst if_rdata",  32'(if_rdata_v[0]),  32'h0);
        chk("arst dm_rdata",  32'(dm_rdata_v[0]),  32'h0);
        chk("arst if_valid",  32'(if_valid_v[0]),  32'h0);
        chk("arst dm_valid",  32'(dm_valid_v[0]),  32'h0);
        @(negedge clk); rst = 1'b1;
        en_cnt = 0; iv_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            en_cnt += int'(mem_en_v[0]);
            iv_cnt += int'(dm_valid_v[0]);
        end
        chk("aborted read dm_valid", 32'(iv_cnt), 32'd0);
        chk("aborted read mem_en", 32'(en_cnt), 32'd0);
        @(negedge clk); dm_req = 1'b1; dm_addr = 8'h62; rd_word = 16'h1357;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk); #1;
            if (dm_valid_v[0]) lat = k;
        end
        chk("fresh read latency", 32'(lat), 32'd4);
        chk("fresh read dm_rdata", 32'(dm_rdata_v[0]), 32'h1357);
        @(negedge clk); dm_req = 1'b0;
        repeat (14) @(negedge clk);

        // Latency builds: LAT=2/1/7 valid at T+4/T+3/T+9
        @(negedge clk); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h70; rd_word = 16'hBEEF;
        first = '{0, 0, 0};
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) dm_req = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) if (dm_valid_v[i] && first[i] == 0) first[i] = k;
        end
        chk("lat2 valid cycle", 32'(first[0]), 32'd4);
        chk("lat1 valid cycle", 32'(first[1]), 32'd3);
        chk("lat7 valid cycle", 32'(first[2]), 32'd9);
        chk("lat1 dm_rdata", 32'(dm_rdata_v[1]), 32'hBEEF);
        chk("lat7 dm_rdata", 32'(dm_rdata_v[2]), 32'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage pipeline. Sequences each access as issue, fixed-latency wait, then a one-cycle response, and drives per-port stall signals into the PC/pipeline-register stall logic. The data port has priority, with a bounded-deferral rule so fetch cannot starve. Sits between the pipeline top level and the memory macro.

## Interface
- AW, 8, address width (matches MEM_SPACE)
- DW, 16, data/instruction width (matches DSIZE/ISIZE)
- LAT, 2, memory read latency in cycles after the issue cycle; legal 1..7
- MAX_DEFER, 2, consecutive fetch losses before fetch is forced to win; legal 1..3

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  AW  fetch address, stable while if_req
- if_kill  in  1  pipeline flush: abandon pending/in-flight fetch
- if_rdata  out  DW  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request, level, held until dm_valid
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_rdata  out  DW  read data, valid with dm_valid
- dm_valid  out  1  one-cycle data completion pulse (reads and writes)
- stall_if  out  1  if_req & ~if_valid
- stall_mem  out  1  dm_req & ~dm_valid
- mem_en  out  1  memory command strobe, one cycle per access
- mem_we  out  1  write qualifier for mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid LAT cycles after the mem_en cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Grant register owner ∈ {FETCH, DATA}.
- IDLE: requests sampled; fetch request masked by if_kill. Data only → DATA; fetch only → FETCH; both → DATA unless defer_cnt == MAX_DEFER, then FETCH. Winner's addr/we/wdata registered; next state ISSUE. No request → stay IDLE.
- defer_cnt: +1 when both request and DATA wins; cleared whenever FETCH is granted; saturates at MAX_DEFER.
- ISSUE: mem_en=1, mem_we=(owner DATA & dm_we); mem_addr/mem_wdata from grant registers. Write → RESP. Read → WAIT, wait counter loaded with LAT.
- WAIT: counter decrements; on the cycle counter==1, mem_rdata captured into the owner's rdata register; next RESP.
- RESP: owner's valid=1 for exactly one cycle; all requests ignored; next IDLE.
- if_kill while owner=FETCH in ISSUE/WAIT sets kill flag; access still runs to completion (memory cannot abort), RESP occurs with if_valid suppressed. Kill flag cleared in IDLE.
- if_kill in RESP of a fetch: if_valid still asserted; pipeline discards it.
- dm_rdata/if_rdata hold their last captured value between accesses.
- Reset (any state, any time): FSM→IDLE, defer_cnt=0, kill flag=0, all outputs 0 (if_rdata, dm_rdata, mem_addr, mem_wdata included). In-flight read data discarded; no valid is produced for it.

## Timing
- Request first sampled in cycle T (state IDLE) → mem_en in T+1.
- Read: data captured end of T+1+LAT; valid in T+2+LAT. LAT=2: valid in T+4.
- Write: valid in T+2.
- Back-to-back: next request sampled the cycle after RESP; read throughput one per LAT+3 cycles.
- stall_if/stall_mem combinational from req and valid; all other outputs registered.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP), owner enum (FETCH, DATA), default LAT and MAX_DEFER constants.
- Sub-module mem_arb_select: combinational winner selection plus defer_cnt register; FSM, latency counter and response registers stay in mem_port_arbiter.

## Test plan
- Reset, LAT=2: fetch read addr 0x10, mem_rdata=0xA5A5 → mem_en cycle 1, if_valid cycle 4 with if_rdata=0xA5A5; stall_if high cycles 0–3.
- Data write addr 0x20, data 0x1234 → mem_en=mem_we=1 cycle 1 with addr 0x20/data 0x1234; dm_valid cycle 2; no fetch activity.
- if_req and dm_req held continuously, MAX_DEFER=2 → grant order DATA, DATA, FETCH, DATA, DATA, FETCH; defer_cnt clears on each FETCH.
- Fetch read issued, if_kill pulsed in WAIT → mem_en once, no if_valid, FSM back in IDLE at T+5; next fetch proceeds normally.
- rst low mid-WAIT of a data read → all outputs 0 immediately; after rst high, no dm_valid for the aborted read; fresh read completes in LAT+2 cycles.
- LAT=1 and LAT=7 builds: single read → valid in T+3 and T+9 respectively.
